// File: rtl/rr_arbiter_8_pkg.sv
// Shared widths, FSM encoding and helpers for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

   localparam int unsigned N_REQ      = 8;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned HOLD_CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // One-hot decode of a requester index.
   function automatic logic [N_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_8_next_idx.sv
// Round-robin search: first set bit of (req & ~mask) strictly after 'last', wrapping.
module rr_next_idx
   import rr_arbiter_8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   localparam int unsigned SH_W = IDX_W + 1;

   logic [N_REQ-1:0] eff;
   logic [N_REQ-1:0] rot;
   logic [SH_W-1:0]  sh;
   logic [IDX_W-1:0] enc;

   // Rotate so that position last+1 lands on bit 0, priority-encode, then un-rotate.
   always_comb begin
      eff   = req & ~mask;
      sh    = SH_W'(last) + SH_W'(1);
      rot   = N_REQ'({eff, eff} >> sh);
      found = |rot;
      enc   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) enc = IDX_W'(i);
      end
      idx   = enc + last + IDX_W'(1);
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered index/one-hot grant and optional hold limit.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   localparam logic [HOLD_CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? HOLD_CNT_W'(0) : HOLD_CNT_W'(MAX_HOLD - 1);
   localparam logic                  HOLD_EN   = (MAX_HOLD != 0);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [HOLD_CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_d;
   logic                   valid_d;
   logic [N_REQ-1:0]       gnt_d;

   logic [N_REQ-1:0]       owner_oh;
   logic [N_REQ-1:0]       pick_mask;
   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic                   others;
   logic                   preempt;

   // Owner is excluded from the search only while a grant is held.
   always_comb begin
      owner_oh  = idx2oh(gnt_idx);
      pick_mask = (state_q == GRANT) ? owner_oh : '0;
      others    = |(req & ~owner_oh);
      preempt   = HOLD_EN && (cnt_q >= HOLD_LAST) && others;
   end

   rr_next_idx u_next_idx (
      .req   (req),
      .mask  (pick_mask),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next-state, pointer, hold counter and output values.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      idx_d   = gnt_idx;
      valid_d = gnt_valid;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               idx_d   = pick_idx;
               valid_d = 1'b1;
               last_d  = pick_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (req[gnt_idx] && !preempt) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + HOLD_CNT_W'(1);
            end else if (pick_found) begin
               idx_d  = pick_idx;
               last_d = pick_idx;
               cnt_d  = '0;
            end else begin
               state_d = IDLE;
               idx_d   = '0;
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
      gnt_d = valid_d ? idx2oh(idx_d) : '0;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= IDX_W'(N_REQ - 1);
         cnt_q     <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         gnt       <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         gnt_idx   <= idx_d;
         gnt_valid <= valid_d;
         gnt       <= gnt_d;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: an unlimited-hold and a MAX_HOLD=4 instance share one request vector.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt0, gnt4;
   logic [2:0] idx0, idx4;
   logic       v0, v4;

   int n_checks;
   int n_errors;

   // Behavioural model per instance: owner (-1 = idle), pointer, cycles held beyond the first.
   int m_owner [2];
   int m_last  [2];
   int m_held  [2];

   rr_arbiter_8 #(.MAX_HOLD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(v0)
   );

   rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(v4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int max_hold(input int k);
      return (k == 0) ? 0 : 4;
   endfunction

   // First requester after 'last' in circular order, skipping 'excl'.
   function automatic int pick(input logic [7:0] r, input int last, input int excl);
      for (int k = 1; k <= 8; k++) begin
         int c;
         c = (last + k) % 8;
         if (r[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1;
         m_last[k]  = 7;
         m_held[k]  = 0;
      end
   endtask

   task automatic model_step(input logic [7:0] r);
      for (int k = 0; k < 2; k++) begin
         int w;
         bit others;
         bit limit;
         if (m_owner[k] < 0) begin
            w = pick(r, m_last[k], -1);
            if (w >= 0) begin
               m_owner[k] = w;
               m_last[k]  = w;
               m_held[k]  = 0;
            end
         end else begin
            others = (r & ~(8'd1 << m_owner[k])) != 8'd0;
            limit  = max_hold(k) != 0 && m_held[k] + 1 >= max_hold(k) && others;
            if (r[m_owner[k]] && !limit) begin
               if (m_held[k] < 255) m_held[k]++;
            end else begin
               w = pick(r, m_last[k], m_owner[k]);
               m_owner[k] = w;
               m_held[k]  = 0;
               if (w >= 0) m_last[k] = w;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] eg;
      for (int k = 0; k < 2; k++) begin
         eg = (m_owner[k] < 0) ? 8'h00 : (8'd1 << m_owner[k]);
         if (k == 0) begin
            check({tag, "/h0 gnt"}, 32'(gnt0), 32'(eg));
            check({tag, "/h0 idx"}, 32'(idx0), (m_owner[k] < 0) ? 32'd0 : 32'(m_owner[k]));
            check({tag, "/h0 valid"}, 32'(v0), 32'(m_owner[k] >= 0));
         end else begin
            check({tag, "/h4 gnt"}, 32'(gnt4), 32'(eg));
            check({tag, "/h4 idx"}, 32'(idx4), (m_owner[k] < 0) ? 32'd0 : 32'(m_owner[k]));
            check({tag, "/h4 valid"}, 32'(v4), 32'(m_owner[k] >= 0));
         end
      end
   endtask

   task automatic step(input logic [7:0] r, input string tag);
      @(negedge clk);
      req = r;
      @(posedge clk);
      #1;
      model_step(r);
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 8'h00;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      req      = 8'h00;
      rst_n    = 1'b0;
      model_reset();
      #12;
      check("reset gnt", 32'({gnt0, gnt4}), 32'd0);
      check("reset idx", 32'({idx0, idx4}), 32'd0);
      check("reset valid", 32'({v0, v4}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester 0, then asynchronous reset mid-grant.
      step(8'h01, "first");
      check("first gnt", 32'(gnt0), 32'h01);
      check("first idx", 32'(idx0), 32'd0);
      check("first valid", 32'(v0), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst gnt", 32'({gnt0, gnt4}), 32'd0);
      check("async rst valid", 32'({v0, v4}), 32'd0);
      model_reset();
      req = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;

      // All requesting; each owner releases after two grant cycles.
      step(8'hFF, "rot start");
      for (int o = 0; o < 9; o++) begin
         check("rot owner", 32'(idx0), 32'(o % 8));
         check("rot valid", 32'(v0), 32'd1);
         step(8'hFF, "rot hold");
         step(8'hFF & ~(8'd1 << (o % 8)), "rot release");
      end

      // Release to idle, then pointer-driven wrap to 0.
      do_reset();
      step(8'h08, "own3");
      check("own3 idx", 32'(idx0), 32'd3);
      step(8'h00, "own3 drop");
      check("own3 idle gnt", 32'(gnt0), 32'h00);
      step(8'h09, "wrap");
      check("wrap idx", 32'(idx0), 32'd0);

      // Hold limit alternation on the MAX_HOLD=4 instance.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(8'h06, "alt");
         check("alt idx", 32'(idx4), ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);
      end

      // Hold limit with no contention: no drop.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(8'h20, "solo");
         check("solo gnt", 32'(gnt4), 32'h20);
      end

      // Release of 6 while 7 arrives and 0 waits.
      do_reset();
      step(8'h40, "h6");
      step(8'h41, "h6 pend0");
      check("h6 idx", 32'(idx0), 32'd6);
      step(8'h81, "rel6");
      check("rel6 idx", 32'(idx0), 32'd7);
      step(8'h01, "rel7");
      check("rel7 idx", 32'(idx0), 32'd0);

      // Random sticky request traffic against the model.
      do_reset();
      begin
         logic [7:0] r;
         r = 8'h00;
         for (int i = 0; i < 3000; i++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
            step(r, "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
